// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch target buffer: default widths,
// 2-bit direction counter encodings, the table entry layout and the counter
// saturation helper.
package bp_pkg;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 4;
    localparam int TAG_W  = ADDR_W - IDX_W - 2;
    localparam int CNT_W  = 16;

    // Direction counter states; the MSB is the taken prediction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [1:0]        ctr;
    } bp_entry_t;

    // Move the counter one step toward the resolved outcome, holding at the ends.
    function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        result = ctr;
        if (taken) begin
            if (ctr != ST) result = ctr + 2'd1;
        end else begin
            if (ctr != SNT) result = ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long run
// never makes the statistics look small again.
module sat_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] count
);

    // Count events, clear on reset, freeze once every bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {COUNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch target buffer with 2-bit direction counters. Fetch looks
// up the registered table; execute-stage resolution trains it, raises the
// flush/recover request and bumps the statistics counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int INDEX_WIDTH   = IDX_W,
    parameter int COUNT_WIDTH   = CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] PCF,
    output logic                     PredictTakenF,
    output logic [ADDRESS_WIDTH-1:0] PCPredF,
    input  logic                     UpdateE,
    input  logic [ADDRESS_WIDTH-1:0] PCE,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    input  logic                     PredictTakenE,
    input  logic [ADDRESS_WIDTH-1:0] PCPredE,
    output logic                     MispredictE,
    output logic [ADDRESS_WIDTH-1:0] PCRecoverE,
    output logic [COUNT_WIDTH-1:0]   BranchCount,
    output logic [COUNT_WIDTH-1:0]   MispredictCount
);

    localparam int ENTRIES   = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH - 2;

    // The entry layout comes from the package, so the table follows its default widths.
    localparam bp_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

    bp_entry_t table_q [ENTRIES];

    logic [INDEX_WIDTH-1:0]   fetch_idx;
    logic [TAG_WIDTH-1:0]     fetch_tag;
    logic [INDEX_WIDTH-1:0]   upd_idx;
    logic [TAG_WIDTH-1:0]     upd_tag;
    bp_entry_t                fetch_entry;
    logic                     fetch_hit;
    logic                     upd_hit;
    logic [ADDRESS_WIDTH-1:0] fetch_seq;
    logic [ADDRESS_WIDTH-1:0] exec_seq;
    logic [ADDRESS_WIDTH-1:0] actual_next;
    logic                     pred_unused;

    assign fetch_idx = PCF[INDEX_WIDTH+1:2];
    assign fetch_tag = PCF[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
    assign upd_idx   = PCE[INDEX_WIDTH+1:2];
    assign upd_tag   = PCE[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
    assign fetch_seq = PCF + ADDRESS_WIDTH'(4);
    assign exec_seq  = PCE + ADDRESS_WIDTH'(4);

    // The carried taken bit is implied by PCPredE, so only the address is compared.
    assign pred_unused = PredictTakenE;

    // Fetch lookup from registered state only, so an update this cycle is not visible yet.
    always_comb begin
        fetch_entry   = table_q[fetch_idx];
        fetch_hit     = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
        PredictTakenF = fetch_hit && fetch_entry.ctr[1];
        PCPredF       = PredictTakenF ? fetch_entry.target : fetch_seq;
    end

    // Compare the real next PC with what fetch assumed; only meaningful with UpdateE.
    always_comb begin
        actual_next = PCSrcE ? PCTargetE : exec_seq;
        upd_hit     = table_q[upd_idx].valid && (table_q[upd_idx].tag == upd_tag);
        MispredictE = UpdateE && (actual_next != PCPredE);
        PCRecoverE  = UpdateE ? actual_next : exec_seq;
    end

    // Train the table: reset wins, hits move the counter, taken misses allocate.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= RESET_ENTRY;
            end
        end else if (UpdateE) begin
            if (upd_hit) begin
                table_q[upd_idx].ctr <= next_ctr(table_q[upd_idx].ctr, PCSrcE);
                if (PCSrcE) begin
                    table_q[upd_idx].target <= PCTargetE;
                end
            end else if (PCSrcE) begin
                table_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: PCTargetE, ctr: WT};
            end
        end
    end

    sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_branch_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (UpdateE),
        .count (BranchCount)
    );

    sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_mispredict_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (MispredictE),
        .count (MispredictCount)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a vector table for the training and
// aliasing walk, plus hand-written reset-with-update and saturation sequences.
module tb_branch_predictor;

    typedef struct {
        logic [31:0] pcf;
        logic        upd;
        logic [31:0] pce;
        logic        src;
        logic [31:0] tgt;
        logic [31:0] prede;
        logic        exp_pt;
        logic [31:0] exp_ppf;
        logic        exp_mis;
        logic [31:0] exp_rec;
        logic [3:0]  exp_bc;
        logic [3:0]  exp_mc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        PredictTakenF;
    logic [31:0] PCPredF;
    logic        UpdateE;
    logic [31:0] PCE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        PredictTakenE;
    logic [31:0] PCPredE;
    logic        MispredictE;
    logic [31:0] PCRecoverE;
    logic [3:0]  BranchCount;
    logic [3:0]  MispredictCount;

    int nVectors     = 0;
    int nMiscompares = 0;

    vec_t vecs[$];

    branch_predictor #(
        .ADDRESS_WIDTH (32),
        .INDEX_WIDTH   (4),
        .COUNT_WIDTH   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .PCF             (PCF),
        .PredictTakenF   (PredictTakenF),
        .PCPredF         (PCPredF),
        .UpdateE         (UpdateE),
        .PCE             (PCE),
        .PCSrcE          (PCSrcE),
        .PCTargetE       (PCTargetE),
        .PredictTakenE   (PredictTakenE),
        .PCPredE         (PCPredE),
        .MispredictE     (MispredictE),
        .PCRecoverE      (PCRecoverE),
        .BranchCount     (BranchCount),
        .MispredictCount (MispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [31:0] pcf, input logic upd, input logic [31:0] pce, input logic src,
        input logic [31:0] tgt, input logic [31:0] prede,
        input logic exp_pt, input logic [31:0] exp_ppf, input logic exp_mis,
        input logic [31:0] exp_rec, input logic [3:0] exp_bc, input logic [3:0] exp_mc);
        vec_t v;
        v.pcf = pcf; v.upd = upd; v.pce = pce; v.src = src; v.tgt = tgt; v.prede = prede;
        v.exp_pt = exp_pt; v.exp_ppf = exp_ppf; v.exp_mis = exp_mis; v.exp_rec = exp_rec;
        v.exp_bc = exp_bc; v.exp_mc = exp_mc;
        return v;
    endfunction

    // Drive one cycle's inputs on the falling edge, away from the sampling edge.
    task automatic applyStimulus(input vec_t v, input logic r);
        @(negedge clk);
        rst           = r;
        PCF           = v.pcf;
        UpdateE       = v.upd;
        PCE           = v.pce;
        PCSrcE        = v.src;
        PCTargetE     = v.tgt;
        PredictTakenE = (v.prede != v.pce + 32'd4);
        PCPredE       = v.prede;
    endtask

    task automatic checkField(input string name, input string field,
                              input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, got, exp);
        end
    endtask

    // Settle, then compare every output against the vector's expectations.
    task automatic checkOutput(input string name, input vec_t v);
        #2;
        nVectors++;
        checkField(name, "PredictTakenF",   {31'b0, PredictTakenF}, {31'b0, v.exp_pt});
        checkField(name, "PCPredF",         PCPredF,                v.exp_ppf);
        checkField(name, "MispredictE",     {31'b0, MispredictE},   {31'b0, v.exp_mis});
        checkField(name, "PCRecoverE",      PCRecoverE,             v.exp_rec);
        checkField(name, "BranchCount",     {28'b0, BranchCount},   {28'b0, v.exp_bc});
        checkField(name, "MispredictCount", {28'b0, MispredictCount}, {28'b0, v.exp_mc});
    endtask

    initial begin
        vec_t v;

        //          pcf           upd  pce           src  tgt          prede         pt   ppf          mis  rec          bc mc
        vecs.push_back(mk(32'h10, 0, 32'h0,  0, 32'h0,   32'h0,   0, 32'h14,  0, 32'h4,   0, 0)); // reset state
        vecs.push_back(mk(32'h10, 1, 32'h10, 1, 32'h40,  32'h14,  0, 32'h14,  1, 32'h40,  0, 0)); // first taken, allocate
        vecs.push_back(mk(32'h10, 0, 32'h10, 0, 32'h0,   32'h0,   1, 32'h40,  0, 32'h14,  1, 1)); // WT predicts taken
        vecs.push_back(mk(32'h10, 1, 32'h10, 1, 32'h40,  32'h40,  1, 32'h40,  0, 32'h40,  1, 1)); // WT -> ST
        vecs.push_back(mk(32'h10, 1, 32'h10, 1, 32'h40,  32'h40,  1, 32'h40,  0, 32'h40,  2, 1)); // ST holds
        vecs.push_back(mk(32'h10, 1, 32'h10, 1, 32'h40,  32'h40,  1, 32'h40,  0, 32'h40,  3, 1)); // ST holds
        vecs.push_back(mk(32'h10, 1, 32'h10, 0, 32'h40,  32'h40,  1, 32'h40,  1, 32'h14,  4, 1)); // ST -> WT
        vecs.push_back(mk(32'h10, 0, 32'h10, 0, 32'h0,   32'h0,   1, 32'h40,  0, 32'h14,  5, 2)); // WT still taken
        vecs.push_back(mk(32'h10, 1, 32'h10, 0, 32'h40,  32'h40,  1, 32'h40,  1, 32'h14,  5, 2)); // WT -> WNT
        vecs.push_back(mk(32'h10, 0, 32'h10, 0, 32'h0,   32'h0,   0, 32'h14,  0, 32'h14,  6, 3)); // WNT falls through
        vecs.push_back(mk(32'h10, 1, 32'h10, 1, 32'h80,  32'h14,  0, 32'h14,  1, 32'h80,  6, 3)); // hit taken, new target
        vecs.push_back(mk(32'h10, 0, 32'h10, 0, 32'h0,   32'h0,   1, 32'h80,  0, 32'h14,  7, 4)); // target replaced
        vecs.push_back(mk(32'h20, 1, 32'h20, 0, 32'h60,  32'h24,  0, 32'h24,  0, 32'h24,  7, 4)); // miss not taken
        vecs.push_back(mk(32'h20, 0, 32'h20, 0, 32'h0,   32'h0,   0, 32'h24,  0, 32'h24,  8, 4)); // nothing allocated
        vecs.push_back(mk(32'h50, 1, 32'h50, 1, 32'h100, 32'h54,  0, 32'h54,  1, 32'h100, 8, 4)); // alias, same-cycle lookup old
        vecs.push_back(mk(32'h10, 0, 32'h10, 0, 32'h0,   32'h0,   0, 32'h14,  0, 32'h14,  9, 5)); // 0x10 evicted
        vecs.push_back(mk(32'h50, 0, 32'h50, 0, 32'h0,   32'h0,   1, 32'h100, 0, 32'h54,  9, 5)); // 0x50 hits
        vecs.push_back(mk(32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 9, 5)); // PC+4 wraps

        rst = 1'b1; PCF = '0; UpdateE = 1'b0; PCE = '0; PCSrcE = 1'b0;
        PCTargetE = '0; PredictTakenE = 1'b0; PCPredE = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset together with an update: mispredict stays combinational, table clears.
        v = mk(32'h50, 1, 32'h30, 1, 32'h200, 32'h34, 1, 32'h100, 1, 32'h200, 9, 5);
        applyStimulus(v, 1'b1);
        checkOutput("rst_upd", v);
        v = mk(32'h50, 0, 32'h30, 0, 32'h0, 32'h0, 0, 32'h54, 0, 32'h34, 0, 0);
        applyStimulus(v, 1'b0);
        checkOutput("rst_clear", v);
        v = mk(32'h30, 0, 32'h30, 0, 32'h0, 32'h0, 0, 32'h34, 0, 32'h34, 0, 0);
        applyStimulus(v, 1'b0);
        checkOutput("rst_noalloc", v);

        // Twenty mispredicting updates drive both 4-bit counters into saturation.
        for (int i = 0; i < 20; i++) begin
            v = mk(32'h0, 1, 32'h30, 1, 32'h200, 32'h34, 0, 32'h4, 1, 32'h200,
                   (i > 15) ? 4'd15 : 4'(i), (i > 15) ? 4'd15 : 4'(i));
            applyStimulus(v, 1'b0);
            checkOutput($sformatf("sat%0d", i), v);
        end
        v = mk(32'h0, 0, 32'h30, 0, 32'h0, 32'h0, 0, 32'h4, 0, 32'h34, 15, 15);
        applyStimulus(v, 1'b0);
        checkOutput("sat_hold", v);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
